fan_mode_ctrl: RTL
==================

# fan_mode_ctrl

Run-mode controller for the desk-fan design. Sequences fan power level (OFF/LOW/MID/HIGH) from the power button, steps the timer stage from the timer button, and forces a ramped stop when the countdown timer expires. Drives the motor through a soft-start duty ramp and an 8-bit PWM. Sits between the debounced button pulses and the fan timer block, whose `state` input it feeds and whose `timeout` output it consumes.

## Interface
- `DUTY_LOW`, 8'd64, target duty for LOW
- `DUTY_MID`, 8'd128, target duty for MID
- `DUTY_HIGH`, 8'd255, target duty for HIGH
- `RAMP_STEP`, 8'd4, duty change per `tick`
- `clk`  in  1  system clock; the block uses only this clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `tick`  in  1  one-cycle ramp strobe (1 ms from the msec divider)
- `btn_pwr`  in  1  one-cycle debounced power-button pulse
- `btn_tim`  in  1  one-cycle debounced timer-button pulse
- `timeout`  in  1  from fan timer: 1 = running or continuous, 0 = expired
- `run`  out  1  fan active (LOW/MID/HIGH); drives timer `state`
- `tim_btn`  out  1  registered one-cycle pulse to the timer button input
- `fan_level`  out  2  0 OFF/STOP, 1 LOW, 2 MID, 3 HIGH
- `tim_stage`  out  2  0 continuous, 1..3 timer stages
- `duty`  out  8  current ramped duty
- `pwm_out`  out  1  motor PWM
- `led`  out  4  one-hot level indicator, {HIGH,MID,LOW,STOP}; 0 in OFF

## Operation
- States: OFF, LOW, MID, HIGH, STOP. Encoding is held in the shared package.
- Transitions on `btn_pwr`: OFF→LOW→MID→HIGH→STOP. `btn_pwr` in STOP is ignored.
- Timer expiry: falling edge of `timeout` (registered previous = 1, current = 0) while in LOW/MID/HIGH → STOP. If it coincides with `btn_pwr`, expiry wins.
- STOP: target duty 0. When `duty == 0`, go to OFF. STOP cannot be aborted.
- Targets: OFF/STOP → 0; LOW/MID/HIGH → the matching parameter.
- Ramp on `tick` only:
  - If duty < target: duty = min(duty+RAMP_STEP, target).
  - If duty > target: duty = max(duty−RAMP_STEP, target).
  - Computed at 9 bits, so there is no wrap at 255 or 0.
- Timer stage: `btn_tim` while `run` is 1 (pre-transition state) increments `tim_stage` mod 4 and emits `tim_btn`. `btn_tim` is ignored when `run` is 0. `tim_stage` clears to 0 on entry to OFF.
- PWM: free-running 8-bit counter. `pwm_out = (cnt < duty)`. Duty 255 gives 255/256 high; duty 0 gives constant low.

## Timing
- Reset values: state OFF, `run` 0, `tim_btn` 0, `fan_level` 0, `tim_stage` 0, `duty` 0, `pwm_out` 0, `led` 0, PWM counter 0, `timeout` history 1.
- Every output is registered.
- `btn_pwr` at edge N: `fan_level`, `run` and `led` update at N+1.
- `btn_tim` at edge N: `tim_btn` is high for exactly cycle N+1; `tim_stage` updates at N+1.
- Expiry is detected one cycle after `timeout` falls. `run` drops in that same cycle, so the timer sees `state` = 0 on the next cycle.
- Ramp: full-scale 0→255 with RAMP_STEP 4 takes 64 ticks.
- `btn_pwr`, `btn_tim` and expiry in the same cycle: expiry → STOP. `btn_tim` is still counted, because the pre-transition `run` was 1.
- `reset_n` asserted mid-ramp: all outputs clear immediately and asynchronously. `pwm_out` goes low at once.

## Structure
- Package `fan_pkg`: state encoding localparams, level codes, default duty constants.
- Sub-module `fan_pwm_gen`: counter and compare, 8-bit `duty` in, `pwm_out` out. Instantiated once.
- FSM, ramp and stage counter stay in the top module.

## Test plan
- Reset, then `btn_pwr` ×1 with `tick` every 10 clk → `fan_level`=1, `run`=1, `duty` reaches 64 after 16 ticks and holds.
- `btn_pwr` ×3 from OFF → HIGH then STOP; `run`=0 immediately; `duty` ramps down 4/tick; OFF when `duty`=0.
- In MID, `btn_tim` ×5 → `tim_stage` sequence 1,2,3,0,1; five one-cycle `tim_btn` pulses. In OFF, `btn_tim` → no pulse, stage 0.
- In LOW with `tim_stage`=2, drive `timeout` 1→0 → STOP next cycle, then OFF with `tim_stage`=0. Holding `timeout`=0 afterwards causes no re-trigger.
- Same-cycle `btn_pwr` + `timeout` fall in MID → STOP, not HIGH.
- Assert `reset_n`=0 at `duty`=100 mid-ramp → `duty`=0, `pwm_out`=0 without a clock edge. Also check `pwm_out` high count = `duty` per 256 clk at `duty` 0, 64, 255.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared definitions for the desk-fan run-mode controller.
// Contents:
//   fan_state_t   - run-mode state encoding (OFF/LOW/MID/HIGH/STOP)
//   LVL_*         - fan_level output codes
//   LED_*         - one-hot level indicator patterns {HIGH,MID,LOW,STOP}
//   *_DEF         - default duty targets and ramp step
//   ramp_duty()   - one saturating ramp step towards a target duty
package fan_pkg;

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_LOW  = 3'd1,
        ST_MID  = 3'd2,
        ST_HIGH = 3'd3,
        ST_STOP = 3'd4
    } fan_state_t;

    localparam logic [1:0] LVL_OFF  = 2'd0;
    localparam logic [1:0] LVL_LOW  = 2'd1;
    localparam logic [1:0] LVL_MID  = 2'd2;
    localparam logic [1:0] LVL_HIGH = 2'd3;

    localparam logic [3:0] LED_NONE = 4'b0000;
    localparam logic [3:0] LED_STOP = 4'b0001;
    localparam logic [3:0] LED_LOW  = 4'b0010;
    localparam logic [3:0] LED_MID  = 4'b0100;
    localparam logic [3:0] LED_HIGH = 4'b1000;

    localparam logic [7:0] DUTY_LOW_DEF  = 8'd64;
    localparam logic [7:0] DUTY_MID_DEF  = 8'd128;
    localparam logic [7:0] DUTY_HIGH_DEF = 8'd255;
    localparam logic [7:0] RAMP_STEP_DEF = 8'd4;

    // Move cur one step towards target without overshooting it. The sums
    // are formed at 9 bits so a step past 255 or below 0 clamps instead of
    // wrapping; bit 8 of the difference flags a borrow below zero.
    function automatic logic [7:0] ramp_duty(input logic [7:0] cur,
                                             input logic [7:0] target,
                                             input logic [7:0] stp);
        logic [8:0] up;
        logic [8:0] dn;
        logic [7:0] res;
        up  = {1'b0, cur} + {1'b0, stp};
        dn  = {1'b0, cur} - {1'b0, stp};
        res = cur;
        if (cur < target) begin
            res = (up > {1'b0, target}) ? target : up[7:0];
        end else if (cur > target) begin
            res = (dn[8] || (dn[7:0] < target)) ? target : dn[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fan_mode_ctrl_if.sv
// Button / timer / motor signal bundle of the fan run-mode controller.
//   tick, btn_pwr, btn_tim, timeout : into the controller
//   run, tim_btn, fan_level, tim_stage, duty, pwm_out, led : out of it
// Modports: master = the side driving buttons and observing outputs,
//           slave  = the controller itself.
interface fan_mode_ctrl_if;

    logic       tick;
    logic       btn_pwr;
    logic       btn_tim;
    logic       timeout;
    logic       run;
    logic       tim_btn;
    logic [1:0] fan_level;
    logic [1:0] tim_stage;
    logic [7:0] duty;
    logic       pwm_out;
    logic [3:0] led;

    modport master (
        output tick, btn_pwr, btn_tim, timeout,
        input  run, tim_btn, fan_level, tim_stage, duty, pwm_out, led
    );

    modport slave (
        input  tick, btn_pwr, btn_tim, timeout,
        output run, tim_btn, fan_level, tim_stage, duty, pwm_out, led
    );

endinterface

// File: rtl/fan_pwm_gen.sv
// 8-bit PWM generator for the fan motor.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   duty     in  8-bit duty; high time is duty/256 of each period
//   pwm_out  out registered PWM output
module fan_pwm_gen (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] duty,
    output logic       pwm_out
);

    logic [7:0] cnt_q, cnt_d;
    logic       pwm_q, pwm_d;

    // A strict less-than keeps duty 0 constantly low and duty 255 low for
    // exactly one count per period.
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        pwm_d = (cnt_q < duty);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 8'd0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/fan_mode_ctrl.sv
// Desk-fan run-mode controller.
// Sequences the power level from the power button, steps the timer stage
// from the timer button, forces a ramped stop when the countdown timer
// expires, ramps the motor duty on each tick and drives the PWM.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   bus      fan_mode_ctrl_if.slave:
//            tick/btn_pwr/btn_tim/timeout in,
//            run/tim_btn/fan_level/tim_stage/duty/pwm_out/led out
module fan_mode_ctrl
    import fan_pkg::*;
#(
    parameter logic [7:0] DUTY_LOW  = DUTY_LOW_DEF,
    parameter logic [7:0] DUTY_MID  = DUTY_MID_DEF,
    parameter logic [7:0] DUTY_HIGH = DUTY_HIGH_DEF,
    parameter logic [7:0] RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    fan_mode_ctrl_if.slave bus
);

    fan_state_t state_q, state_d;
    logic       run_q, run_d;
    logic       tim_btn_q, tim_btn_d;
    logic [1:0] fan_level_q, fan_level_d;
    logic [1:0] tim_stage_q, tim_stage_d;
    logic [7:0] duty_q, duty_d;
    logic [3:0] led_q, led_d;
    logic       timeout_prev_q, timeout_prev_d;
    logic       expire;
    logic       pwm_w;
    logic [7:0] target;

    // Next state. run_q mirrors "state_q is LOW/MID/HIGH", so it doubles as
    // the active qualifier for expiry and the timer button.
    always_comb begin
        state_d        = state_q;
        timeout_prev_d = bus.timeout;
        expire         = timeout_prev_q & ~bus.timeout & run_q;
        case (state_q)
            ST_OFF:  if (bus.btn_pwr) state_d = ST_LOW;
            ST_LOW:  if (expire) state_d = ST_STOP;
                     else if (bus.btn_pwr) state_d = ST_MID;
            ST_MID:  if (expire) state_d = ST_STOP;
                     else if (bus.btn_pwr) state_d = ST_HIGH;
            ST_HIGH: if (expire || bus.btn_pwr) state_d = ST_STOP;
            // STOP cannot be aborted; it only exits once the motor is at rest.
            ST_STOP: if (duty_q == 8'd0) state_d = ST_OFF;
            default: state_d = ST_OFF;
        endcase
    end

    // Level outputs are decoded from the next state so they register on
    // the same edge as the state change.
    always_comb begin
        run_d       = 1'b0;
        fan_level_d = LVL_OFF;
        led_d       = LED_NONE;
        case (state_d)
            ST_LOW:  begin run_d = 1'b1; fan_level_d = LVL_LOW;  led_d = LED_LOW;  end
            ST_MID:  begin run_d = 1'b1; fan_level_d = LVL_MID;  led_d = LED_MID;  end
            ST_HIGH: begin run_d = 1'b1; fan_level_d = LVL_HIGH; led_d = LED_HIGH; end
            ST_STOP: led_d = LED_STOP;
            default: ;
        endcase
    end

    // Duty ramp towards the target of the current state.
    always_comb begin
        case (state_q)
            ST_LOW:  target = DUTY_LOW;
            ST_MID:  target = DUTY_MID;
            ST_HIGH: target = DUTY_HIGH;
            default: target = 8'd0;
        endcase
        duty_d = bus.tick ? ramp_duty(duty_q, target, RAMP_STEP) : duty_q;
    end

    // Timer stage: counted against the pre-transition run flag, so a timer
    // press coinciding with expiry still counts. Entering OFF clears it.
    always_comb begin
        tim_btn_d   = bus.btn_tim & run_q;
        tim_stage_d = tim_stage_q + {1'b0, tim_btn_d};
        if ((state_d == ST_OFF) && (state_q != ST_OFF)) begin
            tim_stage_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_OFF;
            run_q          <= 1'b0;
            tim_btn_q      <= 1'b0;
            fan_level_q    <= LVL_OFF;
            tim_stage_q    <= 2'd0;
            duty_q         <= 8'd0;
            led_q          <= LED_NONE;
            timeout_prev_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            run_q          <= run_d;
            tim_btn_q      <= tim_btn_d;
            fan_level_q    <= fan_level_d;
            tim_stage_q    <= tim_stage_d;
            duty_q         <= duty_d;
            led_q          <= led_d;
            timeout_prev_q <= timeout_prev_d;
        end
    end

    fan_pwm_gen u_pwm (
        .clk     (clk),
        .reset_n (reset_n),
        .duty    (duty_q),
        .pwm_out (pwm_w)
    );

    assign bus.run       = run_q;
    assign bus.tim_btn   = tim_btn_q;
    assign bus.fan_level = fan_level_q;
    assign bus.tim_stage = tim_stage_q;
    assign bus.duty      = duty_q;
    assign bus.pwm_out   = pwm_w;
    assign bus.led       = led_q;

endmodule
